// File: rtl/pwm_multi_ref.sv
// pwm_multi_ref: multi-channel PWM reference generator.
// One shared period counter drives a per-channel duty compare. Each channel
// has a shadow duty, written at any time, and an active duty, which is what
// the compare uses. The active duty is reloaded only at period boundaries,
// or continuously while disabled, so a pulse is never cut short or stretched.
// Build option: define PWM_CENTER_ALIGN_EN for an up/down (centre-aligned)
// counter. The boundary then moves to the valley.

module pwm_multi_ref_ch #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset_central,
  input  logic             en,
  input  logic             load,
  input  logic             wr_hit,
  input  logic [WIDTH-1:0] duty_val,
  input  logic [WIDTH-1:0] cnt,
  output logic             pwm
);

  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] active;

  // Shadow capture, boundary reload of the active duty, and registered compare.
  // A write that lands on a reload cycle goes straight to the active duty.
  always_ff @(posedge clk or posedge reset_central) begin
    if (reset_central) begin
      shadow <= '0;
      active <= '0;
      pwm    <= 1'b0;
    end else begin
      if (wr_hit) shadow <= duty_val;
      if (load)   active <= wr_hit ? duty_val : shadow;
      pwm <= en && (cnt < active);
    end
  end

endmodule

module pwm_multi_ref #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 2,
  parameter int CH_BITS  = 3
) (
  input  logic                clk,
  input  logic                reset_central,
  input  logic                en,
  input  logic [WIDTH-1:0]    period,
  input  logic                duty_wr,
  input  logic [CH_BITS-1:0]  duty_ch,
  input  logic [WIDTH-1:0]    duty_val,
  output logic [CHANNELS-1:0] pwm_out,
  output logic [WIDTH-1:0]    cnt,
  output logic                period_tick
);

  localparam logic [CH_BITS:0] CH_LIM = (CH_BITS+1)'(CHANNELS);

  logic [WIDTH-1:0] period_act;
  logic             wr_ok;
  logic             load;

  // Out-of-range channel indices are dropped here, before any channel decode.
  assign wr_ok = duty_wr && ({1'b0, duty_ch} < CH_LIM);

`ifdef PWM_CENTER_ALIGN_EN
  logic dir_up;

  // The valley (cnt==0) is the only boundary; the counter never rests at 0
  // while running, so the valley occurs once per 2*period_act cycles.
  assign load = !en || (cnt == '0);

  // Up/down counter: peak turns around without repeating, valley restarts up.
  always_ff @(posedge clk or posedge reset_central) begin
    if (reset_central) begin
      cnt        <= '0;
      period_act <= '0;
      dir_up     <= 1'b1;
    end else if (!en) begin
      cnt        <= '0;
      period_act <= period;
      dir_up     <= 1'b1;
    end else if (cnt == '0) begin
      period_act <= period;
      dir_up     <= 1'b1;
      cnt        <= (period != '0) ? WIDTH'(1) : '0;
    end else if (dir_up) begin
      if (cnt >= period_act) begin
        dir_up <= 1'b0;
        cnt    <= cnt - 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= cnt - 1'b1;
    end
  end
`else
  // Boundary when the count reaches the latched period; disabled also reloads.
  assign load = !en || (cnt == period_act);

  // Edge-aligned counter 0..period_act, held at 0 while disabled.
  always_ff @(posedge clk or posedge reset_central) begin
    if (reset_central) begin
      cnt        <= '0;
      period_act <= '0;
    end else if (load) begin
      cnt        <= '0;
      period_act <= period;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`endif

  // Tick follows cnt==0 directly so it is high on the very first enabled cycle.
  assign period_tick = en && (cnt == '0) && !reset_central;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_multi_ref_ch #(.WIDTH(WIDTH)) u_ch (
      .clk           (clk),
      .reset_central (reset_central),
      .en            (en),
      .load          (load),
      .wr_hit        (wr_ok && (duty_ch == CH_BITS'(i))),
      .duty_val      (duty_val),
      .cnt           (cnt),
      .pwm           (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi_ref.sv
// Bench for pwm_multi_ref: table of per-period duty/length checks through a
// scoreboard queue, then hand-written sequences for the timing corner cases.

module tb_pwm_multi_ref;
  localparam int W  = 5;
  localparam int CH = 2;
  localparam int CB = 3;

  logic          clk = 1'b0;
  logic          reset_central;
  logic          en;
  logic [W-1:0]  period;
  logic          duty_wr;
  logic [CB-1:0] duty_ch;
  logic [W-1:0]  duty_val;
  logic [CH-1:0] pwm_out;
  logic [W-1:0]  cnt;
  logic          period_tick;

  pwm_multi_ref #(.WIDTH(W), .CHANNELS(CH), .CH_BITS(CB)) dut (
    .clk           (clk),
    .reset_central (reset_central),
    .en            (en),
    .period        (period),
    .duty_wr       (duty_wr),
    .duty_ch       (duty_ch),
    .duty_val      (duty_val),
    .pwm_out       (pwm_out),
    .cnt           (cnt),
    .period_tick   (period_tick)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct { int per; int d0; int d1; int h0; int h1; int len; } vec_t;
  typedef struct { int h0; int h1; int len; } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // One-cycle write strobe, issued from a negedge.
  task automatic wr(input int ch, input int v);
    duty_wr  = 1'b1;
    duty_ch  = CB'(ch);
    duty_val = W'(v);
    @(negedge clk);
    duty_wr  = 1'b0;
  endtask

  task automatic wait_tick();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (period_tick) begin ok = 1; break; end
    end
    chk("wait_tick", int'(ok), 1);
  endtask

  task automatic wait_cnt(input int v);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (int'(cnt) == v) begin ok = 1; break; end
    end
    chk("wait_cnt", int'(ok), 1);
  endtask

  // Counts cycles and high outputs up to and including the next tick cycle.
  task automatic run_period(output int len, output int h0, output int h1);
    len = 0; h0 = 0; h1 = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      len++;
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      if (period_tick) break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    exp_t e;
    int   len, h0, h1, h;

    vecs.push_back('{31, 14,  4, 14,  4, 32});
    vecs.push_back('{15, 31,  0, 16,  0, 16});
    vecs.push_back('{ 7,  3,  8,  3,  8,  8});
    vecs.push_back('{ 0,  1,  0,  1,  0,  1});
    vecs.push_back('{31,  0, 31,  0, 31, 32});
    vecs.push_back('{ 3,  2,  1,  2,  1,  4});

    reset_central = 1'b1;
    en       = 1'b1;
    period   = '0;
    duty_wr  = 1'b0;
    duty_ch  = '0;
    duty_val = '0;

    #12;
    chk("reset_cnt",  int'(cnt), 0);
    chk("reset_pwm",  int'(pwm_out), 0);
    chk("reset_tick", int'(period_tick), 0);
    @(negedge clk);
    reset_central = 1'b0;

`ifdef PWM_CENTER_ALIGN_EN
    period = 7;
    wr(0, 3);
    wait_tick();
    wait_tick();
    run_period(len, h0, h1);
    chk("center_len", len, 14);
`else
    foreach (vecs[k]) begin
      period = W'(vecs[k].per);
      wr(0, vecs[k].d0);
      wr(1, vecs[k].d1);
      sb.push_back('{vecs[k].h0, vecs[k].h1, vecs[k].len});
      wait_tick();
      wait_tick();
      run_period(len, h0, h1);
      e = sb.pop_front();
      chk($sformatf("vec%0d_len", k), len, e.len);
      chk($sformatf("vec%0d_hi0", k), h0, e.h0);
      chk($sformatf("vec%0d_hi1", k), h1, e.h1);
    end

    // pwm_out lags cnt by one cycle
    period = 31;
    wr(0, 14);
    wr(1, 4);
    wait_tick();
    wait_tick();
    chk("lat_cnt0", int'(cnt), 0);
    chk("lat_pwm_at_cnt0", int'(pwm_out), 0);
    @(negedge clk);
    chk("lat_pwm_at_cnt1", int'(pwm_out), 3);

    // write at cnt=10 leaves the running period alone
    wait_tick();
    h = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      duty_wr = 1'b0;
      h += int'(pwm_out[0]);
      if (int'(cnt) == 10) begin
        duty_wr = 1'b1; duty_ch = 0; duty_val = 20;
      end
      if (period_tick) break;
    end
    duty_wr = 1'b0;
    chk("dbuf_cur_hi0", h, 14);
    run_period(len, h0, h1);
    chk("dbuf_next_hi0", h0, 20);

    // write exactly on the boundary cycle
    wait_cnt(31);
    duty_wr = 1'b1; duty_ch = 0; duty_val = 25;
    @(negedge clk);
    duty_wr = 1'b0;
    chk("bnd_tick", int'(period_tick), 1);
    run_period(len, h0, h1);
    chk("bnd_hi0", h0, 25);
    chk("bnd_len", len, 32);
    wr(0, 14);

    // out-of-range channel is ignored
    wr(3, 9);
    wait_tick();
    wait_tick();
    run_period(len, h0, h1);
    chk("badch_hi0", h0, 14);
    chk("badch_hi1", h1, 4);

    // disable mid-period, then restart with a new period
    wait_cnt(12);
    en = 1'b0;
    period = 7;
    @(negedge clk);
    chk("dis_cnt", int'(cnt), 0);
    chk("dis_pwm", int'(pwm_out), 0);
    chk("dis_tick", int'(period_tick), 0);
    en = 1'b1;
    #1;
    chk("en_first_tick", int'(period_tick), 1);
    run_period(len, h0, h1);
    chk("en_len8", len, 8);
    wait_cnt(2);
    period = 3;
    run_period(len, h0, h1);
    chk("per_change_rest", len, 6);
    run_period(len, h0, h1);
    chk("per_change_new", len, 4);

    // asynchronous reset mid-period
    period = 31;
    wait_tick();
    wait_tick();
    wait_cnt(17);
    #2 reset_central = 1'b1;
    #1;
    chk("arst_cnt", int'(cnt), 0);
    chk("arst_pwm", int'(pwm_out), 0);
    chk("arst_tick", int'(period_tick), 0);
    @(negedge clk);
    reset_central = 1'b0;
    wait_tick();
    run_period(len, h0, h1);
    chk("post_rst_len", len, 32);
    chk("post_rst_hi0", h0, 0);
    chk("post_rst_hi1", h1, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
